// File: rtl/expr_pkg.sv
// Shared definitions for the expression character stream: ASCII codes,
// operator encodings, transmitter state encoding and char helpers.
package expr_pkg;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        OP    = 2'd2,
        FIN   = 2'd3
    } state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return CH_ZERO + {4'h0, d};
    endfunction

    function automatic logic [7:0] op_char(input logic op);
        return (op == OP_MUL) ? CH_STAR : CH_PLUS;
    endfunction

endpackage

// File: rtl/expr_tx_if.sv
// Character stream handshake: one ASCII char per out_valid & out_ready.
interface expr_tx_if;

    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_char,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_char,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/expr_sop_acc.sv
// Sum-of-products accumulator. sum/prod are the registered partial results;
// value is sum+prod as it will stand after this cycle's update, so the
// final result is available in the same cycle the closing digit is applied.
module expr_sop_acc #(
    parameter int RES_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clr,
    input  logic             digit_en,
    input  logic             add_en,
    input  logic [3:0]       d,
    output logic [RES_W-1:0] sum,
    output logic [RES_W-1:0] prod,
    output logic [RES_W-1:0] value
);

    logic [RES_W-1:0] sum_q, sum_d;
    logic [RES_W-1:0] prod_q, prod_d;

    // Next partial sum/product: clear, fold a digit in, or close a product term.
    always_comb begin
        sum_d  = sum_q;
        prod_d = prod_q;
        if (clr) begin
            sum_d  = '0;
            prod_d = RES_W'(1);
        end else if (digit_en) begin
            prod_d = prod_q * RES_W'(d);
        end else if (add_en) begin
            sum_d  = sum_q + prod_q;
            prod_d = RES_W'(1);
        end
        value = sum_d + prod_d;
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sum_q  <= '0;
            prod_q <= '0;
        end else begin
            sum_q  <= sum_d;
            prod_q <= prod_d;
        end
    end

    assign sum  = sum_q;
    assign prod = prod_q;

endmodule

// File: rtl/expr_tx.sv
// Expression transmitter: latches a digit/operator expression, streams it as
// ASCII one char per handshake and evaluates it (* binds tighter than +).
module expr_tx
    import expr_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int RES_W     = 16
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   start,
    input  logic [3:0]             n_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    expr_tx_if.master              tx,
    output logic                   busy,
    output logic                   done,
    output logic [RES_W-1:0]       result,
    output logic                   err
);

    state_t                 state_q, state_d;
    logic [7:0]             out_char_q, out_char_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [RES_W-1:0]       result_q, result_d;
    logic [3:0]             idx_q, idx_d;
    logic [3:0]             n_terms_q, n_terms_d;
    logic [4*MAX_TERMS-1:0] digits_q, digits_d;
    logic [MAX_TERMS-2:0]   ops_q, ops_d;

    logic             xfer;
    logic             start_ok;
    logic [3:0]       cur_digit;
    logic [3:0]       nxt_digit;
    logic             cur_op;
    logic             acc_clr;
    logic             acc_digit_en;
    logic             acc_add_en;
    logic [RES_W-1:0] acc_sum;
    logic [RES_W-1:0] acc_prod;
    logic [RES_W-1:0] acc_value;
    logic             unused_acc;

    assign xfer = out_valid_q & tx.out_ready;

    // Request legality and operand selection by the current term index.
    always_comb begin
        start_ok  = (n_terms != 4'd0) && (int'(n_terms) <= MAX_TERMS);
        cur_digit = '0;
        nxt_digit = '0;
        cur_op    = OP_ADD;
        for (int unsigned i = 0; i < MAX_TERMS; i++) begin
            if (i < 32'(n_terms) && digits[4*i +: 4] > 4'd9) begin
                start_ok = 1'b0;
            end
            if (32'(idx_q) == i) begin
                cur_digit = digits_q[4*i +: 4];
            end
            if (32'(idx_q) + 32'd1 == i) begin
                nxt_digit = digits_q[4*i +: 4];
            end
        end
        for (int unsigned i = 0; i < MAX_TERMS - 1; i++) begin
            if (32'(idx_q) == i) begin
                cur_op = ops_q[i];
            end
        end
    end

    // FSM next state, handshake and registered output values.
    always_comb begin
        state_d      = state_q;
        out_char_d   = out_char_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        result_d     = result_q;
        idx_d        = idx_q;
        n_terms_d    = n_terms_q;
        digits_d     = digits_q;
        ops_d        = ops_q;
        acc_clr      = 1'b0;
        acc_digit_en = 1'b0;
        acc_add_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        state_d     = DIGIT;
                        busy_d      = 1'b1;
                        out_valid_d = 1'b1;
                        out_char_d  = digit_char(digits[3:0]);
                        n_terms_d   = n_terms;
                        digits_d    = digits;
                        ops_d       = ops;
                        idx_d       = '0;
                        acc_clr     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DIGIT: begin
                if (xfer) begin
                    acc_digit_en = 1'b1;
                    if (idx_q == n_terms_q - 4'd1) begin
                        // Closing digit: acc_value already includes it, so the
                        // result lands together with the done pulse.
                        state_d     = FIN;
                        out_valid_d = 1'b0;
                        out_char_d  = '0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        result_d    = acc_value;
                    end else begin
                        state_d    = OP;
                        out_char_d = op_char(cur_op);
                    end
                end
            end
            OP: begin
                if (xfer) begin
                    acc_add_en = (cur_op == OP_ADD);
                    idx_d      = idx_q + 4'd1;
                    state_d    = DIGIT;
                    out_char_d = digit_char(nxt_digit);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single state/output register bank.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            out_char_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            idx_q       <= '0;
            n_terms_q   <= '0;
            digits_q    <= '0;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_char_q  <= out_char_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            n_terms_q   <= n_terms_d;
            digits_q    <= digits_d;
            ops_q       <= ops_d;
        end
    end

    expr_sop_acc #(
        .RES_W (RES_W)
    ) u_acc (
        .clk      (clk),
        .clr_n    (clr_n),
        .clr      (acc_clr),
        .digit_en (acc_digit_en),
        .add_en   (acc_add_en),
        .d        (cur_digit),
        .sum      (acc_sum),
        .prod     (acc_prod),
        .value    (acc_value)
    );

    assign unused_acc = ^{acc_sum, acc_prod};

    assign tx.out_char  = out_char_q;
    assign tx.out_valid = out_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign err          = err_q;

endmodule

// File: tb/tb_expr_tx.sv
// Directed bench for expr_tx: captures the char stream, checks timing,
// back-pressure, evaluation, request rejection and mid-stream reset.
module tb_expr_tx;
    import expr_pkg::*;

    localparam int MT = 8;
    localparam int RW = 16;

    logic        clk     = 1'b0;
    logic        clr_n   = 1'b0;
    logic        start   = 1'b0;
    logic [3:0]  n_terms = '0;
    logic [31:0] digits  = '0;
    logic [6:0]  ops     = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    expr_tx_if txif();

    expr_tx #(
        .MAX_TERMS (MT),
        .RES_W     (RW)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .start   (start),
        .n_terms (n_terms),
        .digits  (digits),
        .ops     (ops),
        .tx      (txif),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one expression, stall on the first '+' for `stall` cycles,
    // collect the chars and compare stream, cycle count and result.
    task automatic run_expr(input string tag, input logic [3:0] n, input logic [31:0] dg,
                            input logic [6:0] op, input int stall,
                            input logic [127:0] exp_str, input logic [15:0] exp_res,
                            input int exp_cycles);
        logic [127:0] buf_s;
        int  cyc;
        int  hold_left;
        bit  got_done;
        bit  stalled;
        buf_s     = '0;
        cyc       = 0;
        hold_left = 0;
        got_done  = 1'b0;
        stalled   = 1'b0;
        txif.out_ready = 1'b1;
        n_terms = n;
        digits  = dg;
        ops     = op;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check({tag, " first"}, {txif.out_valid, busy, txif.out_char},
              {1'b1, 1'b1, 4'h3, dg[3:0]});
        while (!got_done && cyc < 300) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (hold_left > 0) begin
                    check({tag, " hold"}, {txif.out_valid, txif.out_char}, {1'b1, CH_PLUS});
                    hold_left--;
                    txif.out_ready = 1'b0;
                end else if (!stalled && stall > 0 && txif.out_valid && txif.out_char == CH_PLUS) begin
                    stalled        = 1'b1;
                    hold_left      = stall - 1;
                    txif.out_ready = 1'b0;
                end else begin
                    txif.out_ready = 1'b1;
                    if (txif.out_valid) begin
                        buf_s = {buf_s[119:0], txif.out_char};
                    end
                end
                tick();
                cyc++;
            end
        end
        txif.out_ready = 1'b1;
        check({tag, " done_seen"}, got_done, 1'b1);
        check({tag, " stream"}, buf_s, exp_str);
        check({tag, " result"}, result, exp_res);
        check({tag, " cycles"}, cyc, exp_cycles);
        check({tag, " fin_idle"}, {txif.out_valid, busy, err}, 3'b000);
        tick();
        check({tag, " done_pulse"}, {done, busy, txif.out_valid}, 3'b000);
        check({tag, " result_hold"}, result, exp_res);
    endtask

    task automatic reject(input string tag, input logic [3:0] n, input logic [31:0] dg);
        n_terms = n;
        digits  = dg;
        ops     = '0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check({tag, " err"}, {err, busy, txif.out_valid, done}, 4'b1000);
        tick();
        check({tag, " err_pulse"}, {err, busy, txif.out_valid, done}, 4'b0000);
    endtask

    initial begin
        bit saw_done;
        txif.out_ready = 1'b1;
        clr_n = 1'b0;
        tick();
        tick();
        check("reset_state", {txif.out_char, txif.out_valid, busy, done, err, result}, '0);
        clr_n = 1'b1;
        tick();
        check("idle_quiet", {txif.out_valid, busy, done, err}, 4'b0000);

        // 1+2*3 = 7 at full rate, then with '+' stalled 3 cycles
        run_expr("t1", 4'd3, 32'h0000_0321, 7'b0000010, 0, "1+2*3", 16'd7, 5);
        run_expr("t2", 4'd3, 32'h0000_0321, 7'b0000010, 3, "1+2*3", 16'd7, 8);

        // single digit, with garbage in unused high digits
        run_expr("t3a", 4'd1, 32'h0000_0009, 7'b0000000, 0, "9", 16'd9, 1);
        run_expr("t3b", 4'd1, 32'hFFFF_FFF5, 7'b1111111, 0, "5", 16'd5, 1);
        reject("t3_n0", 4'd0, 32'h0000_0001);
        reject("t3_digA", 4'd2, 32'h0000_00A5);
        reject("t3_n9", 4'd9, 32'h1111_1111);

        // 2+3*4+5 = 19
        run_expr("mix", 4'd4, 32'h0000_5432, 7'b0000010, 0, "2+3*4+5", 16'd19, 7);

        // 9^8 mod 2^16
        run_expr("t4", 4'd8, 32'h9999_9999, 7'b1111111, 0, "9*9*9*9*9*9*9*9", 16'd55105, 15);

        // reset after two chars have transferred
        n_terms = 4'd3;
        digits  = 32'h0000_0321;
        ops     = 7'b0000010;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        check("t5_mid_busy", {busy, txif.out_valid, txif.out_char}, {1'b1, 1'b1, 8'h32});
        #1;
        clr_n = 1'b0;
        #1;
        check("t5_async_clr", {txif.out_char, txif.out_valid, busy, done, err, result}, '0);
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_done = saw_done | done;
        end
        clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_done = saw_done | done | busy;
        end
        check("t5_no_done", saw_done, 1'b0);
        run_expr("t5_rerun", 4'd3, 32'h0000_0321, 7'b0000010, 0, "1+2*3", 16'd7, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
